// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the signals exchanged between the 5-stage pipeline datapath and
//   its hazard/sequencing controller.
//
//   master : pipeline side. Drives the IF/ID instruction fields, the EX branch
//            outcome and the drain request. Receives the hold/flush/bubble
//            controls, forwarding selects, drain status and event counters.
//   slave  : controller side (pipe_hazard_ctrl).
//
//   Signals
//     id_valid, id_op[5:0], id_rs/id_rt/id_rd[4:0]  IF/ID instruction
//     ex_br_taken                                   BEQ in EX resolved taken
//     drain_req                                     empty pipeline and halt issue
//     pc_hold, ifid_hold, ifid_flush, idex_bubble   pipeline register controls
//     fwd_a, fwd_b[1:0]                             EX operand sources
//     drained                                       pipeline empty, issue halted
//     stall_cnt, flush_cnt[CNT_W-1:0]               saturating event counters
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic             ex_br_taken;
    logic             drain_req;

    logic             pc_hold;
    logic             ifid_hold;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             drained;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_op, id_rs, id_rt, id_rd, ex_br_taken, drain_req,
        input  pc_hold, ifid_hold, ifid_flush, idex_bubble,
               fwd_a, fwd_b, drained, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_op, id_rs, id_rt, id_rd, ex_br_taken, drain_req,
        output pc_hold, ifid_hold, ifid_flush, idex_bubble,
               fwd_a, fwd_b, drained, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage MIPS pipeline
//   (IF, ID, EX, MEM, WB). Keeps a shadow copy of what sits in ID/EX, EX/MEM
//   and MEM/WB and from it derives:
//     - load-use stalls (PC and IF/ID held, ID/EX bubbled for one cycle)
//     - taken-branch flushes (IF/ID and ID/EX squashed, PC loads the target)
//     - registered EX forwarding selects
//     - a drain/halt handshake (RUN -> DRAIN -> IDLE -> RUN)
//     - saturating stall and flush event counters
//
//   Ports
//     clock    in  rising-edge clock
//     reset_n  in  synchronous reset, active low
//     bus      slave modport of pipe_hazard_ctrl_if (instruction in ID,
//              branch outcome, drain request; pipeline controls out)
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int         CNT_W    = 16,
    parameter logic [5:0] OP_RTYPE = 6'd0,
    parameter logic [5:0] OP_LW    = 6'd35,
    parameter logic [5:0] OP_SW    = 6'd43,
    parameter logic [5:0] OP_BEQ   = 6'd4
) (
    input  logic              clock,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Destination view of an in-flight instruction; all that MEM needs.
    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] dst;
    } dest_t;

    // EX additionally needs to know whether it is a load or a branch.
    typedef struct packed {
        dest_t d;
        logic  ld;
        logic  beq;
    } ex_stage_t;

    state_t     state_q, state_d;
    ex_stage_t  ex_q, ex_d;
    dest_t      mem_q, mem_d;
    logic       wb_valid_q, wb_valid_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // ------------------------------------------------------------------
    // Decode of the instruction sitting in IF/ID
    // ------------------------------------------------------------------
    logic       id_is_rtype;
    logic       id_is_lw;
    logic       id_uses_rt;
    logic [4:0] id_dst;
    logic       id_wr;

    assign id_is_rtype = (bus.id_op == OP_RTYPE);
    assign id_is_lw    = (bus.id_op == OP_LW);
    assign id_uses_rt  = id_is_rtype | (bus.id_op == OP_SW) | (bus.id_op == OP_BEQ);
    assign id_dst      = id_is_rtype ? bus.id_rd : bus.id_rt;
    // Writes to $0 are discarded, so they never create a dependency.
    assign id_wr       = (id_is_rtype | id_is_lw) & (id_dst != 5'd0);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic br;
    logic ld_use;
    logic halt;
    logic hold;
    logic bubble;
    logic issue;

    assign br     = ex_q.d.valid & ex_q.beq & bus.ex_br_taken;
    assign ld_use = bus.id_valid & ex_q.d.valid & ex_q.ld & ex_q.d.wr &
                    ((ex_q.d.dst == bus.id_rs) | (id_uses_rt & (ex_q.d.dst == bus.id_rt)));

    // A taken branch overrides every hold source: the PC must advance to the
    // target and the wrong-path instruction in IF/ID is squashed instead.
    assign hold   = ~br & (ld_use | halt);
    assign bubble = br | hold;
    assign issue  = bus.id_valid & ~bubble;

    // ------------------------------------------------------------------
    // Drain FSM: next state and stage controls
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        halt    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                halt = 1'b1;
                if (!ex_q.d.valid && !mem_q.valid && !wb_valid_q) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                halt = 1'b1;
                if (!bus.drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow advance, forwarding capture and counters
    // ------------------------------------------------------------------
    always_comb begin
        ex_d       = '0;
        mem_d      = ex_q.d;
        wb_valid_d = mem_q.valid;
        fwd_a_d    = 2'b00;
        fwd_b_d    = 2'b00;

        if (issue) begin
            ex_d.d.valid = 1'b1;
            ex_d.d.wr    = id_wr;
            ex_d.d.dst   = id_dst;
            ex_d.ld      = id_is_lw;
            ex_d.beq     = (bus.id_op == OP_BEQ);

            // The instruction now in EX will be in MEM (EX/MEM.ALUOut) and the
            // one in MEM will be in WB (MEM/WB.value) when the issuing one
            // executes. The register file is write-before-read, so nothing
            // older needs forwarding.
            if (ex_q.d.wr && (ex_q.d.dst == bus.id_rs))      fwd_a_d = 2'b10;
            else if (mem_q.wr && (mem_q.dst == bus.id_rs))   fwd_a_d = 2'b01;

            if (ex_q.d.wr && (ex_q.d.dst == bus.id_rt))      fwd_b_d = 2'b10;
            else if (mem_q.wr && (mem_q.dst == bus.id_rt))   fwd_b_d = 2'b01;
        end

        stall_cnt_d = stall_cnt_q;
        if (ld_use && !br && (state_q == ST_RUN) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);

        flush_cnt_d = flush_cnt_q;
        if (br && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_valid_q  <= 1'b0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_valid_q  <= wb_valid_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_hold     = hold;
    assign bus.ifid_hold   = hold;
    assign bus.ifid_flush  = br;
    assign bus.idex_bubble = bubble;
    assign bus.fwd_a       = fwd_a_q;
    assign bus.fwd_b       = fwd_b_q;
    assign bus.drained     = (state_q == ST_IDLE);
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Drives two controllers (16-bit and 2-bit counters) with identical
//   instruction streams and compares them every cycle against a reference
//   model that tracks whole instructions moving through EX/MEM/WB.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;   // not decoded: behaves as a nop

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_IDLE  = 2;

    typedef struct {
        bit       valid;
        bit [5:0] op;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
    } instr_t;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus16 ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

    pipe_hazard_ctrl #(.CNT_W(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: whole instructions in EX, MEM, WB.
    instr_t m_ex, m_mem, m_wb;
    int     m_mode;
    int     m_stall;
    int     m_flush;
    bit [1:0] m_fa, m_fb;
    bit     last_hold;
    bit     last_flush;

    function automatic instr_t nop();
        instr_t i;
        i.valid = 1'b0; i.op = '0; i.rs = '0; i.rt = '0; i.rd = '0;
        return i;
    endfunction

    function automatic instr_t mk(bit [5:0] op, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        instr_t i;
        i.valid = 1'b1; i.op = op; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        case ($urandom_range(0, 4))
            0:       i.op = OP_RTYPE;
            1:       i.op = OP_LW;
            2:       i.op = OP_SW;
            3:       i.op = OP_BEQ;
            default: i.op = OP_ADDI;
        endcase
        i.valid = ($urandom_range(0, 7) != 0);
        i.rs = 5'($urandom_range(0, 3));
        i.rt = 5'($urandom_range(0, 3));
        i.rd = 5'($urandom_range(0, 3));
        return i;
    endfunction

    function automatic bit [4:0] dst_of(instr_t i);
        return (i.op == OP_RTYPE) ? i.rd : i.rt;
    endfunction

    function automatic bit writes(instr_t i);
        return i.valid && (i.op == OP_RTYPE || i.op == OP_LW) && dst_of(i) != 5'd0;
    endfunction

    function automatic bit reads_rt(instr_t i);
        return (i.op == OP_RTYPE) || (i.op == OP_SW) || (i.op == OP_BEQ);
    endfunction

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Source the EX operand will use for register r once the ID instruction issues.
    function automatic bit [1:0] fwd_src(bit [4:0] r);
        if (writes(m_ex) && dst_of(m_ex) == r)   return 2'b10;
        if (writes(m_mem) && dst_of(m_mem) == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // clock the edge, advance the model. Called just after a falling edge.
    task automatic step(input instr_t id, input bit taken, input bit drain, input bit rst_ok);
        bit br, lu, e_hold, e_bubble, issue;
        int next_mode;

        bus16.id_valid = id.valid; bus16.id_op = id.op;
        bus16.id_rs = id.rs; bus16.id_rt = id.rt; bus16.id_rd = id.rd;
        bus16.ex_br_taken = taken; bus16.drain_req = drain;
        bus2.id_valid = id.valid; bus2.id_op = id.op;
        bus2.id_rs = id.rs; bus2.id_rt = id.rt; bus2.id_rd = id.rd;
        bus2.ex_br_taken = taken; bus2.drain_req = drain;
        reset_n = rst_ok;
        #1;

        br = m_ex.valid && m_ex.op == OP_BEQ && taken;
        lu = id.valid && m_ex.valid && m_ex.op == OP_LW && writes(m_ex) &&
             (dst_of(m_ex) == id.rs || (reads_rt(id) && dst_of(m_ex) == id.rt));
        e_hold   = !br && (lu || m_mode != M_RUN);
        e_bubble = br || e_hold;

        check("pc_hold",     32'(bus16.pc_hold),     32'(e_hold));
        check("ifid_hold",   32'(bus16.ifid_hold),   32'(e_hold));
        check("ifid_flush",  32'(bus16.ifid_flush),  32'(br));
        check("idex_bubble", 32'(bus16.idex_bubble), 32'(e_bubble));
        check("fwd_a",       32'(bus16.fwd_a),       32'(m_fa));
        check("fwd_b",       32'(bus16.fwd_b),       32'(m_fb));
        check("drained",     32'(bus16.drained),     32'(m_mode == M_IDLE));
        check("stall_cnt16", 32'(bus16.stall_cnt),   32'(sat(m_stall, 16)));
        check("flush_cnt16", 32'(bus16.flush_cnt),   32'(sat(m_flush, 16)));
        check("stall_cnt2",  32'(bus2.stall_cnt),    32'(sat(m_stall, 2)));
        check("flush_cnt2",  32'(bus2.flush_cnt),    32'(sat(m_flush, 2)));
        check("pc_hold2",    32'(bus2.pc_hold),      32'(e_hold));

        last_hold  = e_hold;
        last_flush = br;

        @(posedge clock);
        if (!rst_ok) begin
            m_ex = nop(); m_mem = nop(); m_wb = nop();
            m_mode = M_RUN; m_stall = 0; m_flush = 0; m_fa = 2'b00; m_fb = 2'b00;
        end else begin
            next_mode = m_mode;
            if (m_mode == M_RUN && drain) next_mode = M_DRAIN;
            if (m_mode == M_DRAIN && !m_ex.valid && !m_mem.valid && !m_wb.valid) next_mode = M_IDLE;
            if (m_mode == M_IDLE && !drain) next_mode = M_RUN;

            if (br) m_flush++;
            if (lu && !br && m_mode == M_RUN) m_stall++;

            issue = id.valid && !e_bubble;
            m_fa  = issue ? fwd_src(id.rs) : 2'b00;
            m_fb  = issue ? fwd_src(id.rt) : 2'b00;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = issue ? id : nop();
            m_mode = next_mode;
        end
        @(negedge clock);
    endtask

    // Presents an instruction in ID until it is accepted (bounded).
    task automatic issue(input instr_t ins, input bit drain);
        for (int k = 0; k < 4; k++) begin
            step(ins, 1'b0, drain, 1'b1);
            if (!last_hold) break;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t cur;
        instr_t held;
        bit     drain;
        bit     rst_ok;
        bit     taken;
        bit     done;

        m_ex = nop(); m_mem = nop(); m_wb = nop();
        m_mode = M_RUN; m_stall = 0; m_flush = 0; m_fa = 2'b00; m_fb = 2'b00;
        reset_n = 1'b0;
        @(negedge clock);

        // Reset with traffic on the inputs.
        step(mk(OP_LW, 5'd1, 5'd2, 5'd0), 1'b1, 1'b1, 1'b0);
        step(mk(OP_RTYPE, 5'd2, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0);
        bus16.drain_req = 1'b0; bus16.ex_br_taken = 1'b0; bus16.id_valid = 1'b0;
        bus2.drain_req = 1'b0;  bus2.ex_br_taken = 1'b0;  bus2.id_valid = 1'b0;
        #1;
        check("rst_pc_hold",     32'(bus16.pc_hold),     32'd0);
        check("rst_ifid_hold",   32'(bus16.ifid_hold),   32'd0);
        check("rst_ifid_flush",  32'(bus16.ifid_flush),  32'd0);
        check("rst_idex_bubble", 32'(bus16.idex_bubble), 32'd0);
        check("rst_fwd_a",       32'(bus16.fwd_a),       32'd0);
        check("rst_fwd_b",       32'(bus16.fwd_b),       32'd0);
        check("rst_drained",     32'(bus16.drained),     32'd0);
        check("rst_stall_cnt",   32'(bus16.stall_cnt),   32'd0);
        check("rst_flush_cnt",   32'(bus16.flush_cnt),   32'd0);
        @(negedge clock);

        // lw $2,0($1); add $3,$2,$4 -> one stall, add forwarded from MEM/WB.
        issue(mk(OP_LW, 5'd1, 5'd2, 5'd0), 1'b0);
        issue(mk(OP_RTYPE, 5'd2, 5'd4, 5'd3), 1'b0);
        check("t2_fwd_a",     32'(bus16.fwd_a),     32'b01);
        check("t2_stall_cnt", 32'(bus16.stall_cnt), 32'd1);

        // add $1,$2,$3; sub $5,$1,$1 -> both operands from EX/MEM.
        issue(mk(OP_RTYPE, 5'd2, 5'd3, 5'd1), 1'b0);
        issue(mk(OP_RTYPE, 5'd1, 5'd1, 5'd5), 1'b0);
        check("t3_fwd_a", 32'(bus16.fwd_a), 32'b10);
        check("t3_fwd_b", 32'(bus16.fwd_b), 32'b10);

        // beq taken in EX -> flush, next EX is a bubble.
        issue(mk(OP_BEQ, 5'd7, 5'd7, 5'd0), 1'b0);
        step(mk(OP_RTYPE, 5'd8, 5'd9, 5'd10), 1'b1, 1'b0, 1'b1);
        step(mk(OP_RTYPE, 5'd11, 5'd12, 5'd13), 1'b0, 1'b0, 1'b1);
        check("t4_flush_cnt", 32'(bus16.flush_cnt), 32'd1);

        // Three instructions, then drain until idle, then release.
        issue(mk(OP_RTYPE, 5'd1, 5'd2, 5'd3), 1'b0);
        issue(mk(OP_RTYPE, 5'd3, 5'd4, 5'd5), 1'b0);
        issue(mk(OP_RTYPE, 5'd5, 5'd6, 5'd7), 1'b0);
        held = mk(OP_RTYPE, 5'd7, 5'd3, 5'd9);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            step(held, 1'b0, 1'b1, 1'b1);
            done = (m_mode == M_IDLE);
        end
        check("t5_drained", 32'(bus16.drained), 32'd1);
        step(held, 1'b0, 1'b0, 1'b1);
        step(held, 1'b0, 1'b0, 1'b1);
        step(nop(), 1'b0, 1'b0, 1'b1);

        // Five load-use stalls saturate the 2-bit counter.
        for (int k = 0; k < 5; k++) begin
            issue(mk(OP_LW, 5'd1, 5'd2, 5'd0), 1'b0);
            issue(mk(OP_RTYPE, 5'd2, 5'd4, 5'd3), 1'b0);
        end
        check("t6_stall_cnt2",  32'(bus2.stall_cnt),  32'd3);
        check("t6_stall_cnt16", 32'(bus16.stall_cnt), 32'd6);

        // beq taken while draining: flush wins over the drain hold.
        issue(mk(OP_BEQ, 5'd9, 5'd9, 5'd0), 1'b1);
        step(mk(OP_RTYPE, 5'd1, 5'd1, 5'd1), 1'b1, 1'b1, 1'b1);
        check("t6_flush_cnt", 32'(bus16.flush_cnt), 32'd2);

        // Randomized traffic; the bench behaves as IF/ID following the model.
        cur = nop();
        drain = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            rst_ok = ($urandom_range(0, 299) != 0);
            taken  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 59) == 0) drain = !drain;
            step(cur, taken, drain, rst_ok);
            if (!rst_ok)          cur = nop();
            else if (last_hold)   cur = cur;
            else if (last_flush)  cur = nop();
            else                  cur = rnd_instr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
